// File: rtl/adc3wire_rx.sv
// Receive side of the ADC 3-wire config port: oversamples clk/data/strobe, mirrors good frames
// into a wishbone-readable shadow bank. Define ADC3WIRE_RX_IRQ_EN to add the sticky irq_o output.
module adc3wire_rx #(
  parameter int ADDR_BITS = 4,
  parameter int DATA_BITS = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  input  logic        spi_clk,
  input  logic        spi_data,
  input  logic        spi_strobe,
  output logic        frame_valid
`ifdef ADC3WIRE_RX_IRQ_EN
  ,
  output logic        irq_o
`endif
);

  localparam int FRAME_BITS = ADDR_BITS + DATA_BITS;
  localparam int CNT_W      = $clog2(FRAME_BITS + 2);
  localparam int WORD_W     = ADDR_BITS + 4;
  localparam int DEPTH      = 2 ** ADDR_BITS;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
  state_t state_q, state_d;

  logic [2:0] clk_sync, stb_sync;
  logic [1:0] dat_sync;
  logic       clk_rise, stb_fall, stb_rise, dat_smp;

  logic [FRAME_BITS-1:0] shift_q, last_q;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DATA_BITS-1:0]  shadow [DEPTH];
  logic [15:0]           frame_cnt;
  logic [7:0]            err_cnt;

  logic                  req, commit, good, busy, status_wr;
  logic [WORD_W-1:0]     word;
  logic [ADDR_BITS-1:0]  shadow_idx;
  logic [31:0]           rdata;
  logic                  unused_ok;

  assign wb_err_o  = 1'b0;
  assign unused_ok = ^{wb_sel_i, wb_dat_i, wb_adr_i[31:ADDR_BITS+6], wb_adr_i[1:0]};

  // Edge flags are registered so data and edge arrive together one cycle after the sync stages.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      clk_sync <= '0;
      stb_sync <= '0;
      dat_sync <= '0;
      clk_rise <= 1'b0;
      stb_fall <= 1'b0;
      stb_rise <= 1'b0;
      dat_smp  <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[1:0], spi_clk};
      stb_sync <= {stb_sync[1:0], spi_strobe};
      dat_sync <= {dat_sync[0], spi_data};
      clk_rise <= clk_sync[1] & ~clk_sync[2];
      stb_fall <= ~stb_sync[1] & stb_sync[2];
      stb_rise <= stb_sync[1] & ~stb_sync[2];
      dat_smp  <= dat_sync[1];
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (stb_fall) state_d = SHIFT;
      SHIFT:   if (stb_rise) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign commit    = (state_q == COMMIT);
  assign good      = commit && (bit_cnt == CNT_FULL);
  assign req       = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign word      = wb_adr_i[ADDR_BITS+5:2];
  assign status_wr = req & wb_we_i & (word == WORD_W'(0));
  assign shadow_idx = ADDR_BITS'(word - WORD_W'(16));

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      shift_q     <= '0;
      bit_cnt     <= '0;
      last_q      <= '0;
      frame_valid <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) shadow[i] <= '0;
    end else begin
      frame_valid <= 1'b0;
      if (state_q == IDLE && stb_fall) begin
        shift_q <= '0;
        bit_cnt <= '0;
      end else if (state_q == SHIFT && clk_rise) begin
        shift_q <= {shift_q[FRAME_BITS-2:0], dat_smp};
        if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 1'b1;
      end
      if (good) begin
        shadow[shift_q[FRAME_BITS-1:DATA_BITS]] <= shift_q[DATA_BITS-1:0];
        last_q      <= shift_q;
        frame_valid <= 1'b1;
      end
    end
  end

  // A STATUS write in the commit cycle wins over the increment.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else if (status_wr) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else if (good) begin
      frame_cnt <= frame_cnt + 16'd1;
    end else if (commit && err_cnt != 8'hFF) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

`ifdef ADC3WIRE_RX_IRQ_EN
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)                                    irq_o <= 1'b0;
    else if (commit)                                 irq_o <= 1'b1;
    else if (req && wb_we_i && word == WORD_W'(2))   irq_o <= 1'b0;
  end
`endif

  always_comb begin
    rdata = '0;
    if (word == WORD_W'(0)) begin
      rdata = {frame_cnt, err_cnt, 7'b0, busy};
    end else if (word == WORD_W'(1)) begin
      rdata[FRAME_BITS-1:0] = last_q;
`ifdef ADC3WIRE_RX_IRQ_EN
    end else if (word == WORD_W'(2)) begin
      rdata[0] = irq_o;
`endif
    end else if (word >= WORD_W'(16) && word < WORD_W'(16 + DEPTH)) begin
      rdata[DATA_BITS-1:0] = shadow[shadow_idx];
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= req;
      if (req) wb_dat_o <= rdata;
    end
  end

endmodule

// File: tb/tb_adc3wire_rx.sv
// Directed bench for adc3wire_rx: serial frames driven bit by bit, results read back over wishbone.
module tb_adc3wire_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_i, dat_o;
  logic        ack, err;
  logic        spi_clk, spi_data, spi_strobe;
  logic        frame_valid;
`ifdef ADC3WIRE_RX_IRQ_EN
  logic        irq;
`endif

  int checks = 0;
  int errors = 0;
  logic [19:0] exp_q[$];
  logic [19:0] exp_last = '0;

  always #5 clk = ~clk;

  adc3wire_rx #(.ADDR_BITS(4), .DATA_BITS(16)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_sel_i(sel), .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_dat_o(dat_o),
    .wb_ack_o(ack), .wb_err_o(err),
    .spi_clk(spi_clk), .spi_data(spi_data), .spi_strobe(spi_strobe),
    .frame_valid(frame_valid)
`ifdef ADC3WIRE_RX_IRQ_EN
    , .irq_o(irq)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wb_access(input logic w, input int word, input logic [31:0] wd, output logic [31:0] rd);
    cyc = 1'b1; stb = 1'b1; we = w; adr = 32'(word) << 2; dat_i = wd;
    @(posedge clk); @(negedge clk);
    check("ack", 32'(ack), 32'd1);
    check("err", 32'(err), 32'd0);
    rd = dat_o;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); @(negedge clk);
    check("ack_drop", 32'(ack), 32'd0);
  endtask

  task automatic rd_check(input string tag, input int word, input logic [31:0] exp);
    logic [31:0] r;
    wb_access(1'b0, word, '0, r);
    check(tag, r, exp);
  endtask

  task automatic wb_write(input int word, input logic [31:0] wd);
    logic [31:0] r;
    wb_access(1'b1, word, wd, r);
  endtask

  task automatic spi_bit(input logic b);
    spi_data = b; spi_clk = 1'b0;
    repeat (4) @(negedge clk);
    spi_clk = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Optional access is issued so its ack edge coincides with the commit edge.
  task automatic send_frame(input logic [31:0] bits, input int nbits, input bit acc,
                            input logic acc_we, input int acc_word,
                            output logic [31:0] acc_data, output int pulses, output int lat);
    if (nbits == 20) exp_q.push_back(bits[19:0]);
    spi_strobe = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = nbits - 1; i >= 0; i--) spi_bit(bits[i]);
    spi_clk = 1'b0;
    repeat (4) @(negedge clk);
    spi_strobe = 1'b1;
    pulses = 0; lat = -1; acc_data = '0;
    for (int i = 1; i <= 24; i++) begin
      @(posedge clk); @(negedge clk);
      if (frame_valid) begin
        pulses++;
        lat = i - 1;
        check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) exp_last = exp_q.pop_front();
      end
      if (acc && i == 4) begin
        cyc = 1'b1; stb = 1'b1; we = acc_we; adr = 32'(acc_word) << 2; dat_i = '0;
      end
      if (acc && i == 5) begin
        check("commit_ack", 32'(ack), 32'd1);
        acc_data = dat_o;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
      end
    end
  endtask

  task automatic frame_ok(input logic [3:0] a, input logic [15:0] d, input bit acc,
                          input logic acc_we, input int acc_word, output logic [31:0] acc_data);
    int pulses, lat;
    send_frame({12'b0, a, d}, 20, acc, acc_we, acc_word, acc_data, pulses, lat);
    check("fv_pulses", 32'(pulses), 32'd1);
    check("fv_latency", 32'(lat), 32'd4);
    rd_check("last_sb", 1, {12'b0, exp_last});
  endtask

  task automatic frame_bad(input logic [31:0] bits, input int nbits);
    int pulses, lat;
    logic [31:0] unused_d;
    send_frame(bits, nbits, 1'b0, 1'b0, 0, unused_d, pulses, lat);
    check("bad_fv_pulses", 32'(pulses), 32'd0);
  endtask

  initial begin
    logic [31:0] r;
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'hF; adr = '0; dat_i = '0;
    spi_clk = 1'b0; spi_data = 1'b0; spi_strobe = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_dat", dat_o, 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_fv", 32'(frame_valid), 32'd0);
    rst = 1'b0;
    repeat (6) @(negedge clk);

    // reset contents
    rd_check("rst_status", 0, 32'd0);
    rd_check("rst_last", 1, 32'd0);
    rd_check("rst_word2", 2, 32'd0);
    for (int w = 16; w < 32; w++) rd_check("rst_shadow", w, 32'd0);
    rd_check("unmapped", 40, 32'd0);

    // single good frame
    frame_ok(4'h3, 16'hBEEF, 1'b0, 1'b0, 0, r);
    rd_check("shadow3", 19, 32'h0000BEEF);
    rd_check("last3", 1, 32'h0003BEEF);
    rd_check("status_one", 0, 32'h00010000);
    wb_write(19, 32'h12345678);
    wb_write(1, 32'hFFFFFFFF);
    rd_check("shadow3_ro", 19, 32'h0000BEEF);
    rd_check("last_ro", 1, 32'h0003BEEF);

    // short and overrun frames
    wb_write(0, 32'd0);
    rd_check("status_clr", 0, 32'd0);
    frame_bad(32'h0007FFFF, 19);
    frame_bad(32'h001A5A5A, 21);
    rd_check("status_err2", 0, 32'h00000200);
    rd_check("shadow3_keep", 19, 32'h0000BEEF);
    rd_check("last_keep", 1, 32'h0003BEEF);

    // STATUS clear coincident with commit
    frame_ok(4'h5, 16'h1234, 1'b1, 1'b1, 0, r);
    rd_check("status_clr_wins", 0, 32'd0);
    rd_check("shadow5", 21, 32'h00001234);

    // shadow read in the commit cycle returns the previous value
    frame_ok(4'h5, 16'hAAAA, 1'b1, 1'b0, 21, r);
    check("commit_read_old", r, 32'h00001234);
    rd_check("shadow5_new", 21, 32'h0000AAAA);
    rd_check("status_one_b", 0, 32'h00010000);

    // reset mid-frame with strobe held low
    spi_strobe = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 6; i++) spi_bit(1'b1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    rd_check("idle_low_strobe", 0, 32'd0);
    for (int i = 0; i < 3; i++) spi_bit(1'b0);
    spi_clk = 1'b0;
    repeat (4) @(negedge clk);
    spi_strobe = 1'b1;
    begin
      int p = 0;
      for (int i = 0; i < 24; i++) begin
        @(posedge clk); @(negedge clk);
        if (frame_valid) p++;
      end
      check("abort_no_fv", 32'(p), 32'd0);
    end
    rd_check("abort_status", 0, 32'd0);
    rd_check("abort_last", 1, 32'd0);
    rd_check("abort_shadow5", 21, 32'd0);
    frame_ok(4'hF, 16'hFFFF, 1'b0, 1'b0, 0, r);
    rd_check("shadow15", 31, 32'h0000FFFF);
    rd_check("status_post", 0, 32'h00010000);

`ifdef ADC3WIRE_RX_IRQ_EN
    check("irq_set_good", 32'(irq), 32'd1);
    rd_check("word2_set", 2, 32'd1);
    wb_write(2, 32'd0);
    check("irq_clear", 32'(irq), 32'd0);
    rd_check("word2_clr", 2, 32'd0);
    frame_bad(32'h00012345, 19);
    check("irq_set_err", 32'(irq), 32'd1);
`else
    wb_write(2, 32'hFFFFFFFF);
    rd_check("word2_none", 2, 32'd0);
`endif

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
